// File: rtl/nonoverlap_pkg.sv
// Shared types and default sizing for the non-overlapping gate-drive block.
// The optional shoot-through fault flag is built only with NONOVERLAP_FAULT_EN.
package nonoverlap_pkg;

  localparam int NUM_CH_DEF = 3;
  localparam int DT_W_DEF   = 5;

  typedef enum logic {
    READY,
    DEAD
  } state_t;

endpackage

// File: rtl/nonoverlap_ch.sv
// One high/low FET channel: change detection, dead-time FSM and registered drives.
// The sticky shoot-through flag exists only when NONOVERLAP_FAULT_EN is defined.
module nonoverlap_ch
  import nonoverlap_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [DT_W-1:0] dead_time,
  input  logic            high_in,
  input  logic            low_in,
  input  logic            fault_clr,
  output logic            high_out,
  output logic            low_out,
  output logic            fault
);

  state_t          state;
  logic [DT_W-1:0] cnt;
  logic [DT_W-1:0] dt_lat;
  logic            prev_high;
  logic            prev_low;
  logic            change;
  logic            follow_high;
  logic            follow_low;

  assign change      = (high_in != prev_high) || (low_in != prev_low);
  // A simultaneous request never reaches either FET.
  assign follow_high = high_in & ~low_in;
  assign follow_low  = low_in & ~high_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= READY;
      cnt       <= '0;
      dt_lat    <= '0;
      prev_high <= 1'b0;
      prev_low  <= 1'b0;
      high_out  <= 1'b0;
      low_out   <= 1'b0;
    end else begin
      prev_high <= high_in;
      prev_low  <= low_in;
      high_out  <= 1'b0;
      low_out   <= 1'b0;
      if (!en) begin
        // Keep re-latching so the dead time after enable uses the current setting.
        state  <= DEAD;
        cnt    <= '0;
        dt_lat <= dead_time;
      end else begin
        case (state)
          READY: begin
            if (change) begin
              state  <= DEAD;
              cnt    <= '0;
              dt_lat <= dead_time;
            end else begin
              high_out <= follow_high;
              low_out  <= follow_low;
            end
          end
          DEAD: begin
            if (change) begin
              cnt    <= '0;
              dt_lat <= dead_time;
            end else if (cnt == dt_lat) begin
              state    <= READY;
              high_out <= follow_high;
              low_out  <= follow_low;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        endcase
      end
    end
  end

`ifdef NONOVERLAP_FAULT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fault <= 1'b0;
    end else if (high_in && low_in) begin
      fault <= 1'b1;
    end else if (fault_clr) begin
      fault <= 1'b0;
    end
  end
`else
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;
  assign fault            = 1'b0;
`endif

endmodule

// File: rtl/nonoverlap_mc.sv
// Multi-channel non-overlap gate driver: one nonoverlap_ch per motor phase.
// NONOVERLAP_FAULT_EN enables the per-channel sticky shoot-through flag.
module nonoverlap_mc
  import nonoverlap_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int DT_W   = DT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DT_W-1:0]   dead_time,
  input  logic [NUM_CH-1:0] highIn,
  input  logic [NUM_CH-1:0] lowIn,
  output logic [NUM_CH-1:0] highOut,
  output logic [NUM_CH-1:0] lowOut,
  input  logic              fault_clr,
  output logic [NUM_CH-1:0] fault
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    nonoverlap_ch #(
      .DT_W(DT_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .dead_time(dead_time),
      .high_in  (highIn[g]),
      .low_in   (lowIn[g]),
      .fault_clr(fault_clr),
      .high_out (highOut[g]),
      .low_out  (lowOut[g]),
      .fault    (fault[g])
    );
  end

endmodule
